// File: rtl/wmem_fetch.sv
// wmem_fetch: streams a contiguous block of weight rows out of a flat weight
// memory. Reads are issued in row-major order. Returned words are tagged with
// their row/column and buffered in a 2-entry FIFO. The FIFO feeds a
// valid/ready stream.
//
// Handshake: a beat transfers in any cycle where w_valid && w_ready. While
// w_valid is high and w_ready is low, every w_* output holds its value.
// w_valid never drops without a transfer. mem_ren qualifies mem_raddr.
// mem_rdata answers it exactly one cycle later.
module wmem_fetch #(
  parameter int DATA_W   = 16,
  parameter int N_IN     = 128,
  parameter int N_HIDDEN = 64,
  localparam int AW = $clog2((N_HIDDEN * N_IN > 2) ? N_HIDDEN * N_IN : 2),
  localparam int HW = $clog2((N_HIDDEN > 2) ? N_HIDDEN : 2),
  localparam int IW = $clog2((N_IN > 2) ? N_IN : 2),
  localparam int RW = $clog2(N_HIDDEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [HW-1:0]            start_h,
  input  logic [RW-1:0]            n_rows,
  output logic [AW-1:0]            mem_raddr,
  output logic                     mem_ren,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic signed [DATA_W-1:0] w_data,
  output logic [HW-1:0]            w_row,
  output logic [IW-1:0]            w_col,
  output logic                     w_last_col,
  output logic                     w_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Read-issue counters. addr_q always equals row_q*N_IN + col_q.
  logic [HW-1:0] row_q;
  logic [IW-1:0] col_q;
  logic [AW-1:0] addr_q;
  logic [HW-1:0] last_row_q;

  // Tags of the single read that may be in flight toward the FIFO.
  logic          inflight_q;
  logic [HW-1:0] if_row_q;
  logic [IW-1:0] if_col_q;
  logic          if_last_q;

  // Two-entry output FIFO.
  logic signed [DATA_W-1:0] f_data [2];
  logic [HW-1:0]            f_row  [2];
  logic [IW-1:0]            f_col  [2];
  logic                     f_last [2];
  logic                     rd_ptr_q, wr_ptr_q;
  logic [1:0]               count_q;

  logic          err_q;

  // Command decode and internal strobes.
  logic [RW:0]   span;
  logic [RW:0]   last_row_full;
  logic          range_bad;
  logic          launch;
  logic          reject;
  logic          pop;
  logic [2:0]    pending;
  logic          room;
  logic          last_issue;
  logic          drained;
  logic          issue;

  assign span          = {1'b0, RW'(start_h)} + {1'b0, n_rows};
  assign last_row_full = span - (RW + 1)'(1);
  assign range_bad     = span > (RW + 1)'(N_HIDDEN);
  assign launch        = (state_q == S_IDLE) && start && (n_rows != '0) && !range_bad;
  assign reject        = (state_q == S_IDLE) && start && (n_rows != '0) && range_bad;

  assign pop        = w_valid && w_ready;
  // Words already committed (buffered plus in flight) after this cycle's pop.
  assign pending    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign room       = pending < 3'd2;
  assign last_issue = (row_q == last_row_q) && (col_q == IW'(N_IN - 1));
  assign drained    = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

  // Next-state logic and read issue.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_rows == '0)    state_d = S_DONE;
          else if (!range_bad) state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (room) begin
          issue = 1'b1;
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, error pulse, address counters and in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      last_row_q <= '0;
      inflight_q <= 1'b0;
      if_row_q   <= '0;
      if_col_q   <= '0;
      if_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= reject;
      inflight_q <= issue;
      if (issue) begin
        if_row_q  <= row_q;
        if_col_q  <= col_q;
        if_last_q <= last_issue;
      end
      if (launch) begin
        row_q      <= start_h;
        col_q      <= '0;
        addr_q     <= AW'(start_h) * AW'(N_IN);
        last_row_q <= last_row_full[HW-1:0];
      end else if (issue && !last_issue) begin
        // Counters stop on the final address so they never run past the block.
        addr_q <= addr_q + AW'(1);
        if (col_q == IW'(N_IN - 1)) begin
          col_q <= '0;
          row_q <= row_q + HW'(1);
        end else begin
          col_q <= col_q + IW'(1);
        end
      end
    end
  end

  // FIFO: push returned read data with its tags, pop on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_row[i]  <= '0;
        f_col[i]  <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      if (inflight_q) begin
        f_data[wr_ptr_q] <= mem_rdata;
        f_row[wr_ptr_q]  <= if_row_q;
        f_col[wr_ptr_q]  <= if_col_q;
        f_last[wr_ptr_q] <= if_last_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign mem_ren    = issue && !rst;
  assign mem_raddr  = rst ? '0 : addr_q;
  assign w_valid    = (count_q != 2'd0);
  assign w_data     = f_data[rd_ptr_q];
  assign w_row      = f_row[rd_ptr_q];
  assign w_col      = f_col[rd_ptr_q];
  assign w_last_col = w_valid && (f_col[rd_ptr_q] == IW'(N_IN - 1));
  assign w_last     = w_valid && f_last[rd_ptr_q];
  assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_wmem_fetch.sv
// Bench for wmem_fetch. It uses a small 4x4 configuration. The reference
// model builds the expected beat stream and address stream directly from the
// command and a memory image.
module tb_wmem_fetch;
  localparam int DATA_W = 16, N_IN = 4, N_HIDDEN = 4;
  localparam int AW = 4, HW = 2, IW = 2, RW = 3;
  localparam int BW = DATA_W + HW + IW + 2;

  logic                     clk, rst, start, w_ready;
  logic [HW-1:0]            start_h;
  logic [RW-1:0]            n_rows;
  logic [AW-1:0]            mem_raddr;
  logic                     mem_ren, w_valid, w_last_col, w_last, busy, done, err;
  logic signed [DATA_W-1:0] mem_rdata, w_data;
  logic [HW-1:0]            w_row;
  logic [IW-1:0]            w_col;

  wmem_fetch #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN)) dut (
    .clk(clk), .rst(rst), .start(start), .start_h(start_h), .n_rows(n_rows),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_row(w_row),
    .w_col(w_col), .w_last_col(w_last_col), .w_last(w_last),
    .busy(busy), .done(done), .err(err)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory with one-cycle read latency. When no read is issued, the
  // data bus carries garbage.
  logic [DATA_W-1:0] mem [0:15];
  always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_raddr] : DATA_W'($urandom);

  int pass_cnt = 0, total_cnt = 0;

  // Scoreboard state.
  logic [BW-1:0] exp_q[$], obs_q[$];
  logic [AW-1:0] exp_addr_q[$], addr_q[$];
  int first_ren, first_valid, last_cyc, done_cyc, err_cyc;
  int done_cnt, err_cnt, last_cnt, ren_cnt, valid_cnt, out_err, stab_err;
  bit finished;
  bit busy_log [0:511];
  logic [30:0] zero_snap;

  function automatic logic [BW-1:0] beat_now();
    return {w_last, w_last_col, w_row, w_col, w_data};
  endfunction

  function automatic logic [30:0] outs_now();
    return {mem_raddr, mem_ren, w_valid, w_data, w_row, w_col, w_last_col, w_last, busy, done, err};
  endfunction

  // Reference model: rows h..h+n-1, columns 0..N_IN-1, in row-major order.
  task automatic build_exp(input int h, input int n);
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = h; r < h + n; r++)
      for (int c = 0; c < N_IN; c++) begin
        logic [HW-1:0] rr;
        logic [IW-1:0] cc;
        rr = HW'(r);
        cc = IW'(c);
        exp_addr_q.push_back(AW'(r * N_IN + c));
        exp_q.push_back({(r == h + n - 1) && (c == N_IN - 1), c == N_IN - 1, rr, cc, mem[r * N_IN + c]});
      end
  endtask

  // Driver and monitor for one command.
  // In cycle 0, start is high. At each negedge, the inputs are driven first;
  // the outputs are then sampled 1ns later.
  task automatic run_cmd(input int h, input int n, input int pct, input int inj_at,
                         input int rst_at, input int max_cyc);
    int held;
    bit pop, prev_stall;
    logic [BW-1:0] prev_beat;
    obs_q.delete(); addr_q.delete();
    first_ren = -1; first_valid = -1; last_cyc = -1; done_cyc = -1; err_cyc = -1;
    done_cnt = 0; err_cnt = 0; last_cnt = 0; ren_cnt = 0; valid_cnt = 0;
    out_err = 0; stab_err = 0; finished = 0; held = 0; prev_stall = 0; prev_beat = '0;
    zero_snap = '1;
    for (int i = 0; i < 512; i++) busy_log[i] = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      rst = (cyc == rst_at);
      start = (cyc == 0) || (cyc == inj_at);
      if (cyc == 0) begin start_h = HW'(h); n_rows = RW'(n); end
      else if (cyc == inj_at) begin start_h = 0; n_rows = 1; end
      w_ready = ($urandom_range(0, 99) < pct);
      #1;
      pop = w_valid && w_ready;
      if (cyc < 512) busy_log[cyc] = busy;
      if (mem_ren) begin
        if (first_ren < 0) first_ren = cyc;
        ren_cnt++;
        addr_q.push_back(mem_raddr);
        if (held - int'(pop) >= 2) out_err++;
      end
      if (w_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (prev_stall && (!w_valid || beat_now() !== prev_beat)) stab_err++;
      prev_stall = w_valid && !w_ready;
      prev_beat = beat_now();
      if (pop) begin
        obs_q.push_back(beat_now());
        if (w_last) begin last_cnt++; last_cyc = cyc; end
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
      if (cyc == rst_at + 1) zero_snap = outs_now();
      held = held + int'(mem_ren) - int'(pop);
      if (rst) begin held = 0; prev_stall = 0; end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin finished = 1; break; end
      if (err_cyc >= 0 && cyc >= err_cyc + 2) begin finished = 1; break; end
    end
    rst = 0; start = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total_cnt++;
    if (outs_now() !== 31'd0) $display("FAIL reset_outputs got %h want 0", outs_now());
    else pass_cnt++;
  endtask

  task automatic test_one_row();
    for (int k = 0; k < 16; k++) mem[k] = DATA_W'(k);
    build_exp(1, 1);
    run_cmd(1, 1, 100, -1, -1, 40);
    total_cnt++; if (obs_q.size() != 4) $display("FAIL one_row_beats got %0d want 4", obs_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      total_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL one_row_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (first_ren !== 1) $display("FAIL one_row_first_ren got %0d want 1", first_ren); else pass_cnt++;
    total_cnt++; if (first_valid !== 3) $display("FAIL one_row_first_valid got %0d want 3", first_valid); else pass_cnt++;
    total_cnt++; if (last_cyc !== 6) $display("FAIL one_row_last_cycle got %0d want 6", last_cyc); else pass_cnt++;
    total_cnt++; if (done_cyc !== 7 || done_cnt !== 1) $display("FAIL one_row_done got cyc %0d cnt %0d want 7 1", done_cyc, done_cnt); else pass_cnt++;
    total_cnt++; if (err_cnt !== 0) $display("FAIL one_row_err got %0d want 0", err_cnt); else pass_cnt++;
    for (int c = 0; c < 9; c++) begin
      total_cnt++;
      if (busy_log[c] !== (c >= 1 && c <= 6)) $display("FAIL one_row_busy_c%0d got %0d want %0d", c, busy_log[c], (c >= 1 && c <= 6));
      else pass_cnt++;
    end
  endtask

  task automatic test_random_ready();
    build_exp(0, 4);
    run_cmd(0, 4, 50, -1, -1, 400);
    total_cnt++; if (!finished) $display("FAIL rr_timeout got 0 want 1"); else pass_cnt++;
    total_cnt++; if (obs_q.size() != 16) $display("FAIL rr_beats got %0d want 16", obs_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      total_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL rr_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (addr_q.size() != 16) $display("FAIL rr_reads got %0d want 16", addr_q.size()); else pass_cnt++;
    foreach (exp_addr_q[i]) begin
      total_cnt++;
      if (i >= addr_q.size() || addr_q[i] !== exp_addr_q[i]) $display("FAIL rr_addr%0d got %0d want %0d", i, addr_q[i], exp_addr_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (out_err !== 0) $display("FAIL rr_outstanding got %0d want 0", out_err); else pass_cnt++;
    total_cnt++; if (stab_err !== 0) $display("FAIL rr_stable got %0d want 0", stab_err); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_cyc + 1) $display("FAIL rr_done_cycle got %0d want %0d", done_cyc, last_cyc + 1); else pass_cnt++;
  endtask

  task automatic test_zero_rows();
    run_cmd(2, 0, 100, -1, -1, 20);
    total_cnt++; if (done_cyc !== 1 || done_cnt !== 1) $display("FAIL zero_done got cyc %0d cnt %0d want 1 1", done_cyc, done_cnt); else pass_cnt++;
    total_cnt++; if (ren_cnt !== 0) $display("FAIL zero_reads got %0d want 0", ren_cnt); else pass_cnt++;
    total_cnt++; if (valid_cnt !== 0) $display("FAIL zero_valid got %0d want 0", valid_cnt); else pass_cnt++;
    total_cnt++; if (err_cnt !== 0) $display("FAIL zero_err got %0d want 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_range_err();
    int bad_h [2] = '{3, 0};
    int bad_n [2] = '{2, 5};
    for (int t = 0; t < 2; t++) begin
      run_cmd(bad_h[t], bad_n[t], 100, -1, -1, 20);
      total_cnt++; if (err_cyc !== 1 || err_cnt !== 1) $display("FAIL range%0d_err got cyc %0d cnt %0d want 1 1", t, err_cyc, err_cnt); else pass_cnt++;
      total_cnt++; if (ren_cnt !== 0) $display("FAIL range%0d_reads got %0d want 0", t, ren_cnt); else pass_cnt++;
      total_cnt++; if (busy_log[1] !== 1'b0 || busy_log[2] !== 1'b0) $display("FAIL range%0d_busy got %0d%0d want 00", t, busy_log[1], busy_log[2]); else pass_cnt++;
      total_cnt++; if (done_cnt !== 0) $display("FAIL range%0d_done got %0d want 0", t, done_cnt); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 16; k++) mem[k] = DATA_W'(k);
    run_cmd(1, 1, 100, -1, 5, 14);
    total_cnt++; if (zero_snap !== 31'd0) $display("FAIL rmid_outputs got %h want 0", zero_snap); else pass_cnt++;
    total_cnt++; if (done_cnt !== 0 || err_cnt !== 0) $display("FAIL rmid_status got done %0d err %0d want 0 0", done_cnt, err_cnt); else pass_cnt++;
    build_exp(2, 1);
    run_cmd(2, 1, 100, -1, -1, 40);
    total_cnt++; if (obs_q.size() != 4) $display("FAIL rmid_next_beats got %0d want 4", obs_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      total_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL rmid_next_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (done_cyc !== 7) $display("FAIL rmid_next_done got %0d want 7", done_cyc); else pass_cnt++;
  endtask

  task automatic test_start_mid();
    build_exp(0, 2);
    run_cmd(0, 2, 70, 3, -1, 200);
    total_cnt++; if (obs_q.size() != 8) $display("FAIL smid_beats got %0d want 8", obs_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      total_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("FAIL smid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1 || done_cyc !== last_cyc + 1) $display("FAIL smid_done got cnt %0d cyc %0d want 1 %0d", done_cnt, done_cyc, last_cyc + 1); else pass_cnt++;
  endtask

  task automatic test_random_cmds();
    int pcts [4] = '{100, 50, 25, 80};
    for (int it = 0; it < 8; it++) begin
      int h, n, p, bad;
      for (int k = 0; k < 16; k++) mem[k] = DATA_W'($urandom);
      h = $urandom_range(0, 3);
      n = $urandom_range(1, 4 - h);
      p = pcts[it % 4];
      build_exp(h, n);
      run_cmd(h, n, p, -1, -1, 500);
      bad = 0;
      foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
      total_cnt++;
      if (bad != 0 || obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_stream got %0d beats %0d wrong want %0d beats", it, obs_q.size(), bad, exp_q.size());
      else pass_cnt++;
      bad = 0;
      foreach (exp_addr_q[i]) if (i >= addr_q.size() || addr_q[i] !== exp_addr_q[i]) bad++;
      total_cnt++;
      if (bad != 0 || addr_q.size() != exp_addr_q.size()) $display("FAIL rnd%0d_addrs got %0d reads %0d wrong want %0d", it, addr_q.size(), bad, exp_addr_q.size());
      else pass_cnt++;
      total_cnt++; if (out_err !== 0 || stab_err !== 0) $display("FAIL rnd%0d_flow got out %0d stab %0d want 0 0", it, out_err, stab_err); else pass_cnt++;
      total_cnt++; if (!finished || done_cnt !== 1 || last_cnt !== 1 || done_cyc !== last_cyc + 1) $display("FAIL rnd%0d_done got fin %0d done %0d last %0d dcyc %0d lcyc %0d want 1 1 1 lcyc+1", it, finished, done_cnt, last_cnt, done_cyc, last_cyc); else pass_cnt++;
      if (p == 100) begin
        total_cnt++;
        if (last_cyc !== 2 + n * N_IN) $display("FAIL rnd%0d_rate got last %0d want %0d", it, last_cyc, 2 + n * N_IN);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_h = '0; n_rows = '0; w_ready = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = DATA_W'(k);
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_one_row();
    test_random_ready();
    test_zero_rows();
    test_range_err();
    test_reset_mid();
    test_start_mid();
    test_random_cmds();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wmem_fetch.md
WMEM_FETCH -- requirements
Module: wmem_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, weight word width in bits.
REQ-002 SHALL have parameter N_IN, default 128, weights per hidden row (columns).
REQ-003 SHALL have parameter N_HIDDEN, default 64, hidden rows; AW = clog2(max(N_HIDDEN*N_IN,2)), HW = clog2(max(N_HIDDEN,2)), IW = clog2(max(N_IN,2)), RW = clog2(N_HIDDEN+1).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  command strobe, sampled only in IDLE.
REQ-007 SHALL have port start_h  input  HW  first hidden row to fetch.
REQ-008 SHALL have port n_rows  input  RW  number of consecutive rows to fetch.
REQ-009 SHALL have port mem_raddr  output  AW  flattened weight-memory read address (row*N_IN + col).
REQ-010 SHALL have port mem_ren  output  1  qualifies mem_raddr as an issued read.
REQ-011 SHALL have port mem_rdata  input  DATA_W signed  memory read data, valid the cycle after mem_ren.
REQ-012 SHALL have port w_valid / w_ready  output / input  1 each  weight stream handshake; transfer when both high.
REQ-013 SHALL have port w_data  output  DATA_W signed  weight word.
REQ-014 SHALL have ports w_row  output  HW, w_col  output  IW  indices of w_data.
REQ-015 SHALL have ports w_last_col  output  1 (col == N_IN-1), w_last  output  1 (final beat of command).
REQ-016 SHALL have ports busy, done, err  output  1 each  status; done and err are one-cycle pulses.

Function
REQ-017 SHALL implement FSM IDLE, FETCH, DRAIN, DONE.
REQ-018 IDLE: start with n_rows==0 -> DONE, no reads; start with start_h+n_rows > N_HIDDEN -> err pulse next cycle, stay IDLE, no reads; otherwise -> FETCH.
REQ-019 FETCH: issue reads in row-major order, col 0..N_IN-1 per row, rows start_h..start_h+n_rows-1; move to DRAIN the cycle after the last read issues.
REQ-020 DRAIN: -> DONE once buffer empty and no read in flight; DONE: assert done one cycle, -> IDLE.
REQ-021 busy SHALL be high in FETCH and DRAIN, low in IDLE and DONE; start ignored while not IDLE.
REQ-022 Read latency is exactly 1: mem_rdata for mem_ren in cycle c is captured at end of cycle c+1 into a 2-entry output FIFO with its row/col/last tags.
REQ-023 mem_ren SHALL assert in cycle c only if (FIFO occupancy + reads in flight - pop in cycle c) < 2; no word is ever dropped or duplicated under any w_ready pattern.
REQ-024 w_valid SHALL reflect FIFO non-empty; w_data/w_row/w_col/w_last_col/w_last SHALL hold stable while w_valid && !w_ready.
REQ-025 With w_ready held high, throughput SHALL be one beat per cycle; start in cycle 0 -> first mem_ren cycle 1 -> first w_valid cycle 3.
REQ-026 done SHALL pulse the cycle after the w_last handshake; w_last SHALL assert on exactly one beat per non-empty command.
REQ-027 Address arithmetic SHALL be AW bits, computed by incrementing counters (no wrap beyond row start_h+n_rows-1).

Reset
REQ-028 rst high at a rising edge SHALL force IDLE, clear FIFO, discard any in-flight read, zero all counters.
REQ-029 During/after reset: mem_raddr=0, mem_ren=0, w_valid=0, w_data=0, w_row=0, w_col=0, w_last_col=0, w_last=0, busy=0, done=0, err=0.
REQ-030 Reset mid-command SHALL abort it without done or err; next start SHALL run normally.

Verification
REQ-031 N_IN=4, N_HIDDEN=4, mem[k]=k; start_h=1, n_rows=1, w_ready=1 -> w_data 4,5,6,7 in cycles 3-6, w_last cycle 6, done cycle 7.
REQ-032 Same memory, start_h=0, n_rows=4, w_ready random 50% -> 16 beats 0..15 in order, w_last_col on 3,7,11,15, never >2 outstanding words.
REQ-033 n_rows=0 -> done in cycle 1, no mem_ren, no w_valid, err=0.
REQ-034 start_h=3, n_rows=2 -> err pulse cycle 1, no mem_ren, busy stays 0.
REQ-035 rst in cycle 5 of REQ-031 command -> all outputs 0 next cycle, no done; new start_h=2, n_rows=1 -> data 8..11.
REQ-036 start pulsed mid-command -> ignored; beat count and done unchanged.
